if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline; sits directly upstream of the combinational instruction memory.
- Owns the PC register and drives the memory address. Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard freeze, branch redirect/flush and self-loop halt detection for end-of-program `B #-1`.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- HALT_WORD, 32'hEAFF_FFFF, encoding of unconditional `B #-1` (branch-to-self) that triggers halt.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  hazard-unit stall; hold PC and IF/ID.
- branch_taken  input  1  branch resolved taken in EXE; redirect and flush.
- branch_address  input  32  branch target.
- instr_mem_pc  output  32  address to instruction memory, equal to the PC register.
- instr_mem_data  input  32  instruction returned combinationally for instr_mem_pc.
- pc_out  output  32  IF/ID: fetched PC + 4.
- instruction_out  output  32  IF/ID: fetched instruction.
- valid_out  output  1  IF/ID entry holds a real instruction.
- halted  output  1  sticky; self-loop detected.

Behaviour:
Reset:
- While rst=1 at an edge: PC=RESET_PC, pc_out=0, instruction_out=0, valid_out=0, halted=0, FSM=RUN.
- Reset has priority over every other input, including mid-freeze and HALT.

Memory interface:
- instr_mem_pc = PC register.
- instr_mem_data is sampled in the same cycle (zero-latency memory).

FSM states: RUN, HALT.

RUN, priority at each edge:
1. branch_taken=1:
   - PC <= branch_address.
   - IF/ID flushed: instruction_out=0, pc_out=0, valid_out=0.
   - Overrides freeze: the frozen ID instruction is on the wrong path.
2. Else if freeze=1: PC, pc_out, instruction_out and valid_out all hold.
3. Else:
   - PC <= PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
   - pc_out <= PC+4.
   - instruction_out <= instr_mem_data.
   - valid_out <= 1.

RUN -> HALT:
- Occurs on an edge where case 3 applies and instr_mem_data == HALT_WORD.
- The halt word is still latched into IF/ID with valid_out=1.
- halted <= 1 on the same edge.
- PC is not advanced; it keeps the halt-word address.

HALT:
- PC and IF/ID hold.
- freeze, branch_taken and branch_address are ignored.
- Only rst exits.

Other rules:
- branch_address is used unaligned as given; the stage performs no alignment check.
- A cycle with no branch and no freeze always produces a valid IF/ID entry; there is no bubble insertion other than flush.

Optional Feature:
Macro IF_STAGE_PERF_EN.
- Defined:
  - Adds outputs fetch_count[31:0], stall_count[31:0] and flush_count[31:0], all reset to 0.
  - fetch_count increments on each case-3 edge.
  - stall_count increments on each case-2 edge.
  - flush_count increments on each case-1 edge.
  - No counter increments in HALT.
  - Counters wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then 3 free-running cycles with memory returning 0xE3A00B01 at PC 0 -> instr_mem_pc 0,4,8,12. After first edge: pc_out=4, instruction_out=0xE3A00B01, valid_out=1.
2. freeze=1 for 2 cycles at PC=8 -> instr_mem_pc stays 8; IF/ID unchanged. On release: PC 12, pc_out=12.
3. branch_taken=1, branch_address=0x70, with freeze=1 simultaneously -> next PC=0x70, valid_out=0, instruction_out=0. Following cycle fetches from 0x70 with valid_out=1.
4. Memory returns 0xEAFFFFFF at PC 0xB8 -> instruction_out=0xEAFFFFFF, valid_out=1, halted=1, PC stays 0xB8. Later branch_taken=1 to 0x0 is ignored.
5. Assert rst while halted and freeze=1 -> PC=0, halted=0, valid_out=0 on next edge. Fetch resumes from 0.
6. With IF_STAGE_PERF_EN, run 5 fetches, 2 stalls, 1 flush, then halt -> fetch_count=5 (plus 1 for the halt word), stall_count=2, flush_count=1. Counts stay constant afterwards.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, branch flush, freeze and self-loop halt.
// Optional IF_STAGE_PERF_EN adds fetch/stall/flush event counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hEAFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] instr_mem_pc,
  input  logic [31:0] instr_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        halted
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] pc_inc_c;

  assign pc_inc_c = XLEN'(pc_q + PC_STEP);

  // State and IF/ID register; reset wins over everything, including HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: branch flush beats freeze; a halt word is latched but the PC stays on it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_d     = branch_address;
          pc_out_d = '0;
          instr_d  = '0;
          valid_d  = 1'b0;
        end else if (!freeze) begin
          pc_out_d = pc_inc_c;
          instr_d  = instr_mem_data;
          valid_d  = 1'b1;
          if (instr_mem_data == HALT_WORD) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign instr_mem_pc    = pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;
  assign halted          = halted_q;

`ifdef IF_STAGE_PERF_EN
  logic            ev_fetch_c, ev_stall_c, ev_flush_c;
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  // Event decode mirrors the RUN priority order; nothing counts in HALT.
  always_comb begin
    ev_fetch_c = 1'b0;
    ev_stall_c = 1'b0;
    ev_flush_c = 1'b0;
    if (state_q == ST_RUN) begin
      ev_flush_c = branch_taken;
      ev_stall_c = !branch_taken && freeze;
      ev_fetch_c = !branch_taken && !freeze;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ev_fetch_c) fetch_cnt_q <= XLEN'(fetch_cnt_q + XLEN'(1));
      if (ev_stall_c) stall_cnt_q <= XLEN'(stall_cnt_q + XLEN'(1));
      if (ev_flush_c) flush_cnt_q <= XLEN'(flush_cnt_q + XLEN'(1));
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction-memory model.
// Counter checks are compiled in when IF_STAGE_PERF_EN is defined.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] instr_mem_pc;
  logic [31:0] instr_mem_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        halted;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_count, stall_count, flush_count;
`endif

  logic [31:0] halt_addr;
  int          n_checks;
  int          n_bad;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .instr_mem_pc   (instr_mem_pc),
    .instr_mem_data (instr_mem_data),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out),
    .halted         (halted)
`ifdef IF_STAGE_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: 0xE3A00B01 at 0, the halt word at halt_addr, else 0xE0000000 | addr.
  always_comb begin
    if (instr_mem_pc == 32'd0)            instr_mem_data = 32'hE3A0_0B01;
    else if (instr_mem_pc == halt_addr)   instr_mem_data = 32'hEAFF_FFFF;
    else                                  instr_mem_data = 32'hE000_0000 | instr_mem_pc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pco,
                            input logic [31:0] ins, input logic v, input logic h);
    check({tag, ".pc"},    instr_mem_pc,          pc);
    check({tag, ".pcout"}, pc_out,                pco);
    check({tag, ".instr"}, instruction_out,       ins);
    check({tag, ".valid"}, {31'd0, valid_out},    {31'd0, v});
    check({tag, ".halt"},  {31'd0, halted},       {31'd0, h});
  endtask

  initial begin
    n_checks       = 0;
    n_bad          = 0;
    halt_addr      = 32'hFFFF_FFF0;
    rst            = 1'b1;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'd0;
    step();
    step();
    rst = 1'b0;
    check_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef IF_STAGE_PERF_EN
    check("rst_fetch", fetch_count, 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_flush", flush_count, 32'd0);
`endif

    // Free-running fetch
    step();
    check_ifid("fetch0", 32'd4, 32'd4, 32'hE3A0_0B01, 1'b1, 1'b0);
    step();
    check_ifid("fetch4", 32'd8, 32'd8, 32'hE000_0004, 1'b1, 1'b0);

    // Freeze holds PC and IF/ID
    freeze = 1'b1;
    step();
    check_ifid("frz1", 32'd8, 32'd8, 32'hE000_0004, 1'b1, 1'b0);
    step();
    check_ifid("frz2", 32'd8, 32'd8, 32'hE000_0004, 1'b1, 1'b0);
    freeze = 1'b0;
    step();
    check_ifid("unfrz", 32'd12, 32'd12, 32'hE000_0008, 1'b1, 1'b0);

    // Branch overrides freeze and flushes
    freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h70;
    step();
    check_ifid("flush", 32'h70, 32'd0, 32'd0, 1'b0, 1'b0);
    freeze = 1'b0; branch_taken = 1'b0;
    step();
    check_ifid("tgt70", 32'h74, 32'h74, 32'hE000_0070, 1'b1, 1'b0);

    // PC wrap at 2^32
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    check("wrap_tgt", instr_mem_pc, 32'hFFFF_FFFC);
    step();
    check_ifid("wrap", 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1, 1'b0);

    // Unaligned target used as given
    branch_taken = 1'b1; branch_address = 32'h71;
    step();
    branch_taken = 1'b0;
    step();
    check_ifid("unalgn", 32'h75, 32'h75, 32'hE000_0071, 1'b1, 1'b0);

    // Self-loop halt at 0xB8
    halt_addr = 32'hB8;
    branch_taken = 1'b1; branch_address = 32'hB0;
    step();
    branch_taken = 1'b0;
    step();
    step();
    check("pre_halt_pc", instr_mem_pc, 32'hB8);
    step();
    check_ifid("halt", 32'hB8, 32'hBC, 32'hEAFF_FFFF, 1'b1, 1'b1);
    branch_taken = 1'b1; branch_address = 32'd0; freeze = 1'b1;
    step();
    freeze = 1'b0;
    step();
    check_ifid("halt_hold", 32'hB8, 32'hBC, 32'hEAFF_FFFF, 1'b1, 1'b1);
    branch_taken = 1'b0;

    // Reset exits HALT even with freeze asserted
    rst = 1'b1; freeze = 1'b1;
    step();
    rst = 1'b0; freeze = 1'b0;
    check_ifid("rst_halt", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check_ifid("resume", 32'd4, 32'd4, 32'hE3A0_0B01, 1'b1, 1'b0);

    // 5 fetches total, 2 stalls, 1 flush, then the halt-word fetch
    step(); step(); step(); step();
    check("run_pc", instr_mem_pc, 32'd20);
    freeze = 1'b1;
    step(); step();
    freeze = 1'b0;
    branch_taken = 1'b1; branch_address = 32'hB8;
    step();
    branch_taken = 1'b0;
    step();
    check_ifid("halt2", 32'hB8, 32'hBC, 32'hEAFF_FFFF, 1'b1, 1'b1);
`ifdef IF_STAGE_PERF_EN
    check("fetch_cnt", fetch_count, 32'd6);
    check("stall_cnt", stall_count, 32'd2);
    check("flush_cnt", flush_count, 32'd1);
    freeze = 1'b1;
    step();
    freeze = 1'b0; branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    step();
    check("fetch_hold", fetch_count, 32'd6);
    check("stall_hold", stall_count, 32'd2);
    check("flush_hold", flush_count, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
